// File: rtl/cpu_defs_pkg.sv
// ---------------------------------------------------------------------------
// cpu_defs_pkg
// Shared definitions for the multi-cycle CPU control path.
//   state_e      : sequencer state encoding (IF=0 ... WB=4, HALT=7)
//   ITYPE_*      : IR instr_type field codes
//   OP_*         : per-type opcode constants used by the classifier
//   PC_SRC_*     : PC source select codes driven onto pc_src
// ---------------------------------------------------------------------------
package cpu_defs_pkg;

    typedef enum logic [2:0] {
        ST_IF   = 3'd0,
        ST_ID   = 3'd1,
        ST_EX   = 3'd2,
        ST_MEM  = 3'd3,
        ST_WB   = 3'd4,
        ST_HALT = 3'd7
    } state_e;

    localparam logic [1:0] ITYPE_R = 2'b00;
    localparam logic [1:0] ITYPE_I = 2'b01;
    localparam logic [1:0] ITYPE_J = 2'b10;
    localparam logic [1:0] ITYPE_S = 2'b11;

    // R-type: AND, ADD, SUB, CMP occupy 0..3
    localparam logic [4:0] OP_R_LAST = 5'd3;

    // I-type: ANDI, ADDI, LW, SW, BEQ occupy 0..4
    localparam logic [4:0] OP_I_LW   = 5'd2;
    localparam logic [4:0] OP_I_SW   = 5'd3;
    localparam logic [4:0] OP_I_BEQ  = 5'd4;

    localparam logic [4:0] OP_J_JMP  = 5'd0;
    localparam logic [4:0] OP_J_CALL = 5'd1;
    localparam logic [4:0] OP_J_RET  = 5'd2;

    // S-type: 0..3
    localparam logic [4:0] OP_S_LAST = 5'd3;

    localparam logic [1:0] PC_SRC_INC    = 2'b00;
    localparam logic [1:0] PC_SRC_JUMP   = 2'b01;
    localparam logic [1:0] PC_SRC_REG    = 2'b10;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b11;

endpackage

// File: rtl/instr_classify.sv
// ---------------------------------------------------------------------------
// instr_classify
// Purely combinational decode of the raw IR type/opcode fields into the
// handful of flags the sequencer needs to pick its path.
// Ports:
//   instr_type [1:0] in  : IR type field (R/I/J/S)
//   opcode     [4:0] in  : IR opcode field
//   legal           out : encoding is one of the defined instructions
//   is_jmp/call/ret out : J-type control transfers
//   is_beq          out : conditional branch
//   is_mem          out : LW or SW (needs the MEM state)
//   is_lw           out : LW (needs MDR load and WB)
// ---------------------------------------------------------------------------
module instr_classify
    import cpu_defs_pkg::*;
(
    input  logic [1:0] instr_type,
    input  logic [4:0] opcode,
    output logic       legal,
    output logic       is_jmp,
    output logic       is_call,
    output logic       is_ret,
    output logic       is_beq,
    output logic       is_mem,
    output logic       is_lw
);

    always_comb begin
        legal   = 1'b0;
        is_jmp  = 1'b0;
        is_call = 1'b0;
        is_ret  = 1'b0;
        is_beq  = 1'b0;
        is_mem  = 1'b0;
        is_lw   = 1'b0;
        case (instr_type)
            ITYPE_R: begin
                legal = (opcode <= OP_R_LAST);
            end
            ITYPE_I: begin
                legal  = (opcode <= OP_I_BEQ);
                is_lw  = (opcode == OP_I_LW);
                is_mem = (opcode == OP_I_LW) || (opcode == OP_I_SW);
                is_beq = (opcode == OP_I_BEQ);
            end
            ITYPE_J: begin
                is_jmp  = (opcode == OP_J_JMP);
                is_call = (opcode == OP_J_CALL);
                is_ret  = (opcode == OP_J_RET);
                legal   = is_jmp || is_call || is_ret;
            end
            ITYPE_S: begin
                legal = (opcode <= OP_S_LAST);
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// multicycle_sequencer
// Multi-cycle state controller placed after the combinational main control
// unit. Walks each instruction through IF/ID/EX/MEM/WB and produces the
// per-cycle load enables, memory strobes and PC source select. Illegal
// encodings park the machine in HALT until reset. Also keeps free-running
// cycle and retired-instruction counters (both wrap modulo 2^CNT_W).
// Ports:
//   clk, reset (sync, active-high)
//   run                 : allow new fetches
//   instr_type, opcode  : raw IR fields
//   cu_reg_wr/mem_read/mem_write : control-unit decode of the IR
//   zero                : ALU zero flag (valid in EX)
//   imem_ready, dmem_ready : memory handshakes
//   state               : current state encoding
//   imem_req, ir_write, pc_write, pc_src, ab_write, alu_out_write,
//   dmem_rd, dmem_wr, mdr_write, rf_write, link_write : datapath controls
//   illegal             : sticky illegal-instruction flag
//   cycle_count, retired_count : performance counters
// ---------------------------------------------------------------------------
module multicycle_sequencer
    import cpu_defs_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic [1:0]       instr_type,
    input  logic [4:0]       opcode,
    input  logic             cu_reg_wr,
    input  logic             cu_mem_read,
    input  logic             cu_mem_write,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic [2:0]       state,
    output logic             imem_req,
    output logic             ir_write,
    output logic             pc_write,
    output logic [1:0]       pc_src,
    output logic             ab_write,
    output logic             alu_out_write,
    output logic             dmem_rd,
    output logic             dmem_wr,
    output logic             mdr_write,
    output logic             rf_write,
    output logic             link_write,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] retired_count
);

    state_e             state_q, state_d;
    logic               pending_q, pending_d;
    logic               illegal_q, illegal_d;
    logic [CNT_W-1:0]   cycle_count_q, cycle_count_d;
    logic [CNT_W-1:0]   retired_count_q, retired_count_d;
    logic               retire;
    logic               fetch_req;

    logic               legal;
    logic               is_jmp;
    logic               is_call;
    logic               is_ret;
    logic               is_beq;
    logic               is_mem;
    logic               is_lw;

    instr_classify u_classify (
        .instr_type (instr_type),
        .opcode     (opcode),
        .legal      (legal),
        .is_jmp     (is_jmp),
        .is_call    (is_call),
        .is_ret     (is_ret),
        .is_beq     (is_beq),
        .is_mem     (is_mem),
        .is_lw      (is_lw)
    );

    // A fetch that has been raised must be held until the memory answers,
    // so pending_q keeps the request alive after run drops.
    assign fetch_req = (state_q == ST_IF) && (run || pending_q);

    always_comb begin
        state_d       = state_q;
        pending_d     = pending_q;
        illegal_d     = illegal_q;
        retire        = 1'b0;
        imem_req      = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        pc_src        = PC_SRC_INC;
        ab_write      = 1'b0;
        alu_out_write = 1'b0;
        dmem_rd       = 1'b0;
        dmem_wr       = 1'b0;
        mdr_write     = 1'b0;
        rf_write      = 1'b0;
        link_write    = 1'b0;

        case (state_q)
            ST_IF: begin
                imem_req = fetch_req;
                if (fetch_req && imem_ready) begin
                    ir_write  = 1'b1;
                    pc_write  = 1'b1;
                    pc_src    = PC_SRC_INC;
                    pending_d = 1'b0;
                    state_d   = ST_ID;
                end else begin
                    pending_d = fetch_req;
                end
            end
            ST_ID: begin
                ab_write = 1'b1;
                if (!legal) begin
                    illegal_d = 1'b1;
                    state_d   = ST_HALT;
                end else if (is_jmp || is_call) begin
                    pc_write   = 1'b1;
                    pc_src     = PC_SRC_JUMP;
                    link_write = is_call;
                    retire     = 1'b1;
                    state_d    = ST_IF;
                end else if (is_ret) begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_REG;
                    retire   = 1'b1;
                    state_d  = ST_IF;
                end else begin
                    state_d = ST_EX;
                end
            end
            ST_EX: begin
                alu_out_write = 1'b1;
                // Branch retires here whether or not it is taken; zero only
                // decides whether the PC actually loads the target.
                if (is_beq) begin
                    pc_src   = PC_SRC_BRANCH;
                    pc_write = zero;
                    retire   = 1'b1;
                    state_d  = ST_IF;
                end else if (is_mem) begin
                    state_d = ST_MEM;
                end else if (!cu_reg_wr) begin
                    retire  = 1'b1;
                    state_d = ST_IF;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                dmem_rd = cu_mem_read;
                dmem_wr = cu_mem_write;
                if (dmem_ready) begin
                    if (is_lw) begin
                        mdr_write = 1'b1;
                        state_d   = ST_WB;
                    end else begin
                        retire  = 1'b1;
                        state_d = ST_IF;
                    end
                end
            end
            ST_WB: begin
                rf_write = cu_reg_wr;
                retire   = 1'b1;
                state_d  = ST_IF;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_IF;
            end
        endcase

        cycle_count_d   = (state_q != ST_HALT) ? cycle_count_q + CNT_W'(1) : cycle_count_q;
        retired_count_d = retire ? retired_count_q + CNT_W'(1) : retired_count_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= ST_IF;
            pending_q       <= 1'b0;
            illegal_q       <= 1'b0;
            cycle_count_q   <= '0;
            retired_count_q <= '0;
        end else begin
            state_q         <= state_d;
            pending_q       <= pending_d;
            illegal_q       <= illegal_d;
            cycle_count_q   <= cycle_count_d;
            retired_count_q <= retired_count_d;
        end
    end

    assign state         = state_q;
    assign illegal       = illegal_q;
    assign cycle_count   = cycle_count_q;
    assign retired_count = retired_count_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_multicycle_sequencer
// Directed scenarios for reset, ALU, load with wait states, branch, call,
// illegal/HALT, fetch hold-over and reset during an access, followed by a
// randomized instruction stream checked cycle by cycle against a phase-level
// model of the sequencer. Counters run at 6 bits so wrap-around is exercised.
// ---------------------------------------------------------------------------
module tb_multicycle_sequencer;

    localparam int CNT_W = 6;

    localparam int S_IMEM = 9;
    localparam int S_IRW  = 8;
    localparam int S_PCW  = 7;
    localparam int S_AB   = 6;
    localparam int S_ALU  = 5;
    localparam int S_DRD  = 4;
    localparam int S_DWR  = 3;
    localparam int S_MDR  = 2;
    localparam int S_RF   = 1;
    localparam int S_LINK = 0;

    logic             clk = 1'b0;
    logic             reset;
    logic             run;
    logic [1:0]       instr_type;
    logic [4:0]       opcode;
    logic             cu_reg_wr;
    logic             cu_mem_read;
    logic             cu_mem_write;
    logic             zero;
    logic             imem_ready;
    logic             dmem_ready;
    logic [2:0]       state;
    logic             imem_req;
    logic             ir_write;
    logic             pc_write;
    logic [1:0]       pc_src;
    logic             ab_write;
    logic             alu_out_write;
    logic             dmem_rd;
    logic             dmem_wr;
    logic             mdr_write;
    logic             rf_write;
    logic             link_write;
    logic             illegal;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] retired_count;

    int n_cmp  = 0;
    int n_fail = 0;

    // One expected clock cycle of the reference model
    typedef struct {
        logic [2:0] st;
        logic [1:0] ty;
        logic [4:0] op;
        logic       zr;
        logic       rn;
        logic       irdy;
        logic       drdy;
        logic [9:0] strb;
        logic       pcs_chk;
        logic [1:0] pcs;
        logic       ret;
        logic       to_halt;
    } cyc_t;

    cyc_t       plan[$];
    logic [1:0] p_ty;
    logic [4:0] p_op;
    logic       p_zr;

    always #5 clk = ~clk;

    multicycle_sequencer #(.CNT_W(CNT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .run           (run),
        .instr_type    (instr_type),
        .opcode        (opcode),
        .cu_reg_wr     (cu_reg_wr),
        .cu_mem_read   (cu_mem_read),
        .cu_mem_write  (cu_mem_write),
        .zero          (zero),
        .imem_ready    (imem_ready),
        .dmem_ready    (dmem_ready),
        .state         (state),
        .imem_req      (imem_req),
        .ir_write      (ir_write),
        .pc_write      (pc_write),
        .pc_src        (pc_src),
        .ab_write      (ab_write),
        .alu_out_write (alu_out_write),
        .dmem_rd       (dmem_rd),
        .dmem_wr       (dmem_wr),
        .mdr_write     (mdr_write),
        .rf_write      (rf_write),
        .link_write    (link_write),
        .illegal       (illegal),
        .cycle_count   (cycle_count),
        .retired_count (retired_count)
    );

    // Highest legal opcode per instruction type
    function automatic int max_op(input logic [1:0] ty);
        case (ty)
            2'b00:   return 3;
            2'b01:   return 4;
            2'b10:   return 2;
            default: return 3;
        endcase
    endfunction

    // What the upstream control unit would produce: {reg_wr, mem_read, mem_write}
    function automatic logic [2:0] cu_decode(input logic [1:0] ty, input logic [4:0] op);
        case (ty)
            2'b00:   return {(op != 5'd3), 2'b00};
            2'b01:   return {(op <= 5'd2), (op == 5'd2), (op == 5'd3)};
            2'b10:   return 3'b000;
            default: return 3'b100;
        endcase
    endfunction

    task automatic set_ir(input logic [1:0] ty, input logic [4:0] op);
        instr_type = ty;
        opcode     = op;
        {cu_reg_wr, cu_mem_read, cu_mem_write} = cu_decode(ty, op);
    endtask

    // Leaves the bench 1 time unit after a clock edge with reset released
    task automatic do_reset();
        reset      = 1'b1;
        run        = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        zero       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset      = 1'b1;
        run        = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        zero       = 1'b1;
        set_ir(2'b01, 5'd2);
        repeat (2) @(posedge clk);
        #1;
        run = 1'b0;
        #1;
        n_cmp++; if (state !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_state: got %0d want 0", state); end
        n_cmp++; if ({imem_req, ir_write, pc_write, ab_write, alu_out_write, dmem_rd, dmem_wr, mdr_write, rf_write, link_write} !== 10'b0) begin
            n_fail++; $display("[TB] FAIL reset_strobes: got %b want 0", {imem_req, ir_write, pc_write, ab_write, alu_out_write, dmem_rd, dmem_wr, mdr_write, rf_write, link_write});
        end
        n_cmp++; if (pc_src !== 2'b00) begin n_fail++; $display("[TB] FAIL reset_pc_src: got %b want 00", pc_src); end
        n_cmp++; if (illegal !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_illegal: got %b want 0", illegal); end
        n_cmp++; if (cycle_count !== '0 || retired_count !== '0) begin
            n_fail++; $display("[TB] FAIL reset_counters: got %0d/%0d want 0/0", cycle_count, retired_count);
        end
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge clk);
            #1;
            imem_ready = 1'($urandom);
            #1;
            n_cmp++; if (state !== 3'd0 || imem_req !== 1'b0) begin
                n_fail++; $display("[TB] FAIL idle_no_fetch: got state %0d req %b want 0/0", state, imem_req);
            end
        end
        n_cmp++; if (cycle_count !== CNT_W'(3) || retired_count !== '0) begin
            n_fail++; $display("[TB] FAIL idle_counters: got %0d/%0d want 3/0", cycle_count, retired_count);
        end
    endtask

    task automatic test_add();
        do_reset();
        set_ir(2'b00, 5'd1);
        run        = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_cmp++; if (state !== ((i == 3) ? 3'd4 : 3'(i))) begin
                n_fail++; $display("[TB] FAIL add_state[%0d]: got %0d want %0d", i, state, (i == 3) ? 4 : i);
            end
            n_cmp++; if (rf_write !== (i == 3)) begin
                n_fail++; $display("[TB] FAIL add_rf_write[%0d]: got %b want %b", i, rf_write, (i == 3));
            end
            @(posedge clk);
            #1;
            run = 1'b0;
        end
        #1;
        n_cmp++; if (state !== 3'd0 || retired_count !== CNT_W'(1) || cycle_count !== CNT_W'(4)) begin
            n_fail++; $display("[TB] FAIL add_retire: got state %0d ret %0d cyc %0d want 0/1/4", state, retired_count, cycle_count);
        end
    endtask

    task automatic test_lw_wait();
        int wds[2];
        int wd;
        int total;
        wds[0] = 3;
        wds[1] = $urandom_range(0, 5);
        for (int k = 0; k < 2; k++) begin
            wd    = wds[k];
            total = 5 + wd;
            do_reset();
            set_ir(2'b01, 5'd2);
            run        = 1'b1;
            imem_ready = 1'b1;
            for (int i = 0; i < total; i++) begin
                dmem_ready = (i == 3 + wd);
                #1;
                n_cmp++; if (state !== ((i < 3) ? 3'(i) : (i <= 3 + wd) ? 3'd3 : 3'd4)) begin
                    n_fail++; $display("[TB] FAIL lw_state[%0d] wait %0d: got %0d", i, wd, state);
                end
                n_cmp++; if ({dmem_rd, dmem_wr, mdr_write} !== {(i >= 3 && i <= 3 + wd), 1'b0, (i == 3 + wd)}) begin
                    n_fail++; $display("[TB] FAIL lw_mem[%0d] wait %0d: got rd/wr/mdr %b", i, wd, {dmem_rd, dmem_wr, mdr_write});
                end
                @(posedge clk);
                #1;
                run = 1'b0;
            end
            #1;
            n_cmp++; if (state !== 3'd0 || retired_count !== CNT_W'(1) || cycle_count !== CNT_W'(total)) begin
                n_fail++; $display("[TB] FAIL lw_retire: got state %0d ret %0d cyc %0d want 0/1/%0d", state, retired_count, cycle_count, total);
            end
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            set_ir(2'b01, 5'd4);
            zero       = 1'(z);
            run        = 1'b1;
            imem_ready = 1'b1;
            for (int i = 0; i < 3; i++) begin
                #1;
                n_cmp++; if (state !== 3'(i)) begin n_fail++; $display("[TB] FAIL beq_state[%0d]: got %0d want %0d", i, state, i); end
                if (i == 2) begin
                    n_cmp++; if ({pc_write, pc_src} !== {1'(z), 2'b11}) begin
                        n_fail++; $display("[TB] FAIL beq_pc zero=%0d: got pcw/src %b want %b", z, {pc_write, pc_src}, {1'(z), 2'b11});
                    end
                end
                @(posedge clk);
                #1;
                run = 1'b0;
            end
            #1;
            n_cmp++; if (state !== 3'd0 || retired_count !== CNT_W'(1)) begin
                n_fail++; $display("[TB] FAIL beq_retire zero=%0d: got state %0d ret %0d want 0/1", z, state, retired_count);
            end
        end
    endtask

    task automatic test_call();
        do_reset();
        set_ir(2'b10, 5'd1);
        run        = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (state !== 3'(i)) begin n_fail++; $display("[TB] FAIL call_state[%0d]: got %0d want %0d", i, state, i); end
            if (i == 1) begin
                n_cmp++; if ({pc_write, pc_src, link_write} !== 4'b1011) begin
                    n_fail++; $display("[TB] FAIL call_id: got pcw/src/link %b want 1011", {pc_write, pc_src, link_write});
                end
            end
            @(posedge clk);
            #1;
            run = 1'b0;
        end
        #1;
        n_cmp++; if (state !== 3'd0 || retired_count !== CNT_W'(1) || link_write !== 1'b0) begin
            n_fail++; $display("[TB] FAIL call_retire: got state %0d ret %0d link %b want 0/1/0", state, retired_count, link_write);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        set_ir(2'b10, 5'd7);
        run        = 1'b1;
        imem_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (state !== 3'(i)) begin n_fail++; $display("[TB] FAIL ill_state[%0d]: got %0d want %0d", i, state, i); end
            @(posedge clk);
            #1;
        end
        for (int i = 0; i < 5; i++) begin
            dmem_ready = 1'($urandom);
            #1;
            n_cmp++; if (state !== 3'd7 || illegal !== 1'b1) begin
                n_fail++; $display("[TB] FAIL ill_halt[%0d]: got state %0d illegal %b want 7/1", i, state, illegal);
            end
            n_cmp++; if (cycle_count !== CNT_W'(2) || imem_req !== 1'b0) begin
                n_fail++; $display("[TB] FAIL ill_frozen[%0d]: got cyc %0d req %b want 2/0", i, cycle_count, imem_req);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (state !== 3'd0 || illegal !== 1'b0 || cycle_count !== '0) begin
            n_fail++; $display("[TB] FAIL ill_reset: got state %0d illegal %b cyc %0d want 0/0/0", state, illegal, cycle_count);
        end
    endtask

    task automatic test_run_drop();
        do_reset();
        set_ir(2'b00, 5'd1);
        run        = 1'b1;
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            imem_ready = (i == 2);
            #1;
            n_cmp++; if ({state, imem_req, ir_write} !== {3'd0, 1'b1, (i == 2)}) begin
                n_fail++; $display("[TB] FAIL hold_fetch[%0d]: got state %0d req %b irw %b", i, state, imem_req, ir_write);
            end
            @(posedge clk);
            #1;
            run = 1'b0;
        end
        for (int i = 0; i < 6; i++) begin
            imem_ready = 1'($urandom);
            #1;
            n_cmp++; if (state !== ((i == 0) ? 3'd1 : (i == 1) ? 3'd2 : (i == 2) ? 3'd4 : 3'd0) || imem_req !== 1'b0) begin
                n_fail++; $display("[TB] FAIL no_refetch[%0d]: got state %0d req %b", i, state, imem_req);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid_access();
        do_reset();
        set_ir(2'b01, 5'd3);
        run        = 1'b1;
        imem_ready = 1'b1;
        dmem_ready = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            run = 1'b0;
        end
        #1;
        n_cmp++; if (state !== 3'd3 || dmem_wr !== 1'b1) begin
            n_fail++; $display("[TB] FAIL sw_in_mem: got state %0d wr %b want 3/1", state, dmem_wr);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if ({state, imem_req, dmem_rd, dmem_wr} !== 6'b000_000) begin
            n_fail++; $display("[TB] FAIL reset_drops_access: got state %0d req/rd/wr %b want 0/000", state, {imem_req, dmem_rd, dmem_wr});
        end
        reset = 1'b0;
    endtask

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c.st      = st;
        c.ty      = p_ty;
        c.op      = p_op;
        c.zr      = p_zr;
        c.rn      = 1'($urandom);
        c.irdy    = 1'($urandom);
        c.drdy    = 1'($urandom);
        c.strb    = '0;
        c.pcs_chk = 1'b0;
        c.pcs     = 2'b00;
        c.ret     = 1'b0;
        c.to_halt = 1'b0;
        return c;
    endfunction

    // Appends the expected cycles of one instruction (idle gap, fetch with
    // wait states, then its execution phases) to the plan queue.
    function automatic void plan_instr(input bit bad);
        cyc_t       c;
        int         wi;
        int         wd;
        logic [2:0] cu;
        bit         lw;
        bit         sw;
        bit         beq;
        p_ty = 2'($urandom);
        p_zr = 1'($urandom);
        if (bad) p_op = 5'($urandom_range(max_op(p_ty) + 1, 31));
        else     p_op = 5'($urandom_range(0, max_op(p_ty)));
        cu  = cu_decode(p_ty, p_op);
        lw  = (p_ty == 2'b01) && (p_op == 5'd2);
        sw  = (p_ty == 2'b01) && (p_op == 5'd3);
        beq = (p_ty == 2'b01) && (p_op == 5'd4);

        repeat ($urandom_range(0, 2)) begin
            c = blank(3'd0);
            c.rn = 1'b0;
            plan.push_back(c);
        end
        wi = $urandom_range(0, 3);
        for (int i = 0; i <= wi; i++) begin
            c = blank(3'd0);
            c.rn   = (i == 0) ? 1'b1 : 1'($urandom);
            c.irdy = (i == wi);
            c.strb[S_IMEM] = 1'b1;
            if (i == wi) begin
                c.strb[S_IRW] = 1'b1;
                c.strb[S_PCW] = 1'b1;
                c.pcs_chk     = 1'b1;
                c.pcs         = 2'b00;
            end
            plan.push_back(c);
        end

        c = blank(3'd1);
        c.strb[S_AB] = 1'b1;
        if (bad) begin
            c.to_halt = 1'b1;
            plan.push_back(c);
            repeat (4) plan.push_back(blank(3'd7));
            return;
        end
        if (p_ty == 2'b10) begin
            c.strb[S_PCW]  = 1'b1;
            c.strb[S_LINK] = (p_op == 5'd1);
            c.pcs_chk      = 1'b1;
            c.pcs          = (p_op == 5'd2) ? 2'b10 : 2'b01;
            c.ret          = 1'b1;
            plan.push_back(c);
            return;
        end
        plan.push_back(c);

        c = blank(3'd2);
        c.strb[S_ALU] = 1'b1;
        if (beq) begin
            c.strb[S_PCW] = p_zr;
            c.pcs_chk     = 1'b1;
            c.pcs         = 2'b11;
            c.ret         = 1'b1;
            plan.push_back(c);
            return;
        end
        if (lw || sw) begin
            plan.push_back(c);
            wd = $urandom_range(0, 3);
            for (int j = 0; j <= wd; j++) begin
                c = blank(3'd3);
                c.strb[S_DRD] = lw;
                c.strb[S_DWR] = sw;
                c.drdy        = (j == wd);
                if (j == wd) begin
                    c.strb[S_MDR] = lw;
                    c.ret         = sw;
                end
                plan.push_back(c);
            end
            if (sw) return;
        end else begin
            c.ret = !cu[2];
            plan.push_back(c);
            if (!cu[2]) return;
        end

        c = blank(3'd4);
        c.strb[S_RF] = cu[2];
        c.ret        = 1'b1;
        plan.push_back(c);
    endfunction

    task automatic test_random_program();
        cyc_t       c;
        logic [9:0] obs;
        int         exp_cyc;
        int         exp_ret;
        bit         exp_ill;
        int         step;
        do_reset();
        exp_cyc = 0;
        exp_ret = 0;
        exp_ill = 1'b0;
        step    = 0;
        plan.delete();
        for (int k = 0; k < 70; k++) plan_instr(1'b0);
        plan_instr(1'($urandom_range(0, 1)));
        while (plan.size() > 0) begin
            c          = plan.pop_front();
            run        = c.rn;
            imem_ready = c.irdy;
            dmem_ready = c.drdy;
            zero       = c.zr;
            set_ir(c.ty, c.op);
            #1;
            obs = {imem_req, ir_write, pc_write, ab_write, alu_out_write, dmem_rd, dmem_wr, mdr_write, rf_write, link_write};
            n_cmp++; if (state !== c.st) begin
                n_fail++; $display("[TB] FAIL rnd_state step %0d: got %0d want %0d", step, state, c.st);
            end
            n_cmp++; if (obs !== c.strb) begin
                n_fail++; $display("[TB] FAIL rnd_strobes step %0d state %0d: got %b want %b", step, c.st, obs, c.strb);
            end
            if (c.pcs_chk) begin
                n_cmp++; if (pc_src !== c.pcs) begin
                    n_fail++; $display("[TB] FAIL rnd_pc_src step %0d: got %b want %b", step, pc_src, c.pcs);
                end
            end
            n_cmp++; if (illegal !== exp_ill) begin
                n_fail++; $display("[TB] FAIL rnd_illegal step %0d: got %b want %b", step, illegal, exp_ill);
            end
            n_cmp++; if (cycle_count !== CNT_W'(exp_cyc) || retired_count !== CNT_W'(exp_ret)) begin
                n_fail++; $display("[TB] FAIL rnd_counters step %0d: got %0d/%0d want %0d/%0d", step, cycle_count, retired_count, CNT_W'(exp_cyc), CNT_W'(exp_ret));
            end
            n_cmp++; if ($countones({imem_req, dmem_rd, dmem_wr}) > 1) begin
                n_fail++; $display("[TB] FAIL rnd_one_request step %0d: got req/rd/wr %b want at most one", step, {imem_req, dmem_rd, dmem_wr});
            end
            @(posedge clk);
            #1;
            if (c.st != 3'd7) exp_cyc++;
            if (c.ret)        exp_ret++;
            if (c.to_halt)    exp_ill = 1'b1;
            step++;
        end
        #1;
        n_cmp++; if (cycle_count !== CNT_W'(exp_cyc) || retired_count !== CNT_W'(exp_ret)) begin
            n_fail++; $display("[TB] FAIL rnd_final_counters: got %0d/%0d want %0d/%0d", cycle_count, retired_count, CNT_W'(exp_cyc), CNT_W'(exp_ret));
        end
    endtask

    initial begin
        $display("[TB] starting multicycle_sequencer bench");
        test_reset();
        test_add();
        test_lw_wait();
        test_beq();
        test_call();
        test_illegal();
        test_run_drop();
        test_reset_mid_access();
        test_random_program();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: bench did not complete within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
